// File: rtl/vga_fb_arbiter.sv
// Time-slot arbiter for a single-port framebuffer RAM: one display prefetch per
// 8-pixel group, all remaining cycles granted to a host valid/ready port.
module vga_fb_arbiter #(
  parameter int H_TOTAL  = 768,
  parameter int H_ACTIVE = 512,
  parameter int V_TOTAL  = 512,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_we,
  input  logic [14:0] host_addr,
  input  logic [23:0] host_wdata,
  output logic [23:0] host_rdata,
  output logic        host_rvalid,
  output logic        ram_en,
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic [23:0] ram_wdata,
  input  logic [23:0] ram_rdata,
  output logic [23:0] disp_word,
  output logic        disp_load
);

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HRD} tag_t;

  localparam logic [9:0] X_LINE_END   = 10'(H_TOTAL - 8);
  localparam logic [9:0] X_ACTIVE_END = 10'(H_ACTIVE - 8);
  localparam logic [8:0] Y_LAST       = 9'(V_TOTAL - 1);
  // V_ACTIVE may be 512, which does not fit in the 9-bit line count.
  localparam logic [9:0] Y_ACTIVE     = 10'(V_ACTIVE);

  logic       at_line_end;
  logic       fetch;
  logic       host_go;
  logic [8:0] tgt_line;
  logic [5:0] tgt_group;
  tag_t       issue_tag;
  tag_t       tag_cmd;
  tag_t       tag_ret;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    at_line_end = (pix_x == X_LINE_END);
    tgt_line    = pix_y;
    tgt_group   = pix_x[8:3] + 6'd1;
    if (at_line_end) begin
      tgt_line  = (pix_y == Y_LAST) ? 9'd0 : pix_y + 9'd1;
      tgt_group = 6'd0;
    end
    fetch = (pix_x[2:0] == 3'd0) && ((pix_x < X_ACTIVE_END) || at_line_end)
            && ({1'b0, tgt_line} < Y_ACTIVE);
  end

  assign host_ready = !fetch && rst_n;
  assign host_go    = host_valid && host_ready;

  always_comb begin
    issue_tag = TAG_NONE;
    if (fetch)                   issue_tag = TAG_DISP;
    else if (host_go && !host_we) issue_tag = TAG_HRD;
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values; the async reset clears in-flight tags so no stale pulse
  // can follow a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      tag_cmd     <= TAG_NONE;
      tag_ret     <= TAG_NONE;
      disp_word   <= '0;
      disp_load   <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      ram_en  <= fetch || host_go;
      ram_we  <= host_go && host_we;
      if (fetch) begin
        ram_addr <= {tgt_line, tgt_group};
      end else if (host_go) begin
        ram_addr  <= host_addr;
        ram_wdata <= host_wdata;
      end

      tag_cmd <= issue_tag;
      tag_ret <= tag_cmd;

      disp_load   <= (tag_ret == TAG_DISP);
      host_rvalid <= (tag_ret == TAG_HRD);
      if (tag_ret == TAG_DISP) disp_word  <= ram_rdata;
      if (tag_ret == TAG_HRD)  host_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: stimulus pushes expected RAM commands and
// responses from a spec-level model; a negedge monitor pops and compares.
module tb_vga_fb_arbiter;

  localparam int H_TOTAL  = 768;
  localparam int H_ACTIVE = 512;
  localparam int V_TOTAL  = 512;
  localparam int V_ACTIVE = 480;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  pix_x = '0;
  logic [8:0]  pix_y = '0;
  logic        host_valid = 1'b0;
  logic        host_we = 1'b0;
  logic [14:0] host_addr = '0;
  logic [23:0] host_wdata = '0;
  logic        host_ready, host_rvalid, ram_en, ram_we, disp_load;
  logic [23:0] host_rdata, ram_wdata, disp_word;
  logic [14:0] ram_addr;
  logic [23:0] ram_rdata = '0;

  vga_fb_arbiter #(
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .disp_word(disp_word), .disp_load(disp_load)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int disp_cnt = 0;

  typedef struct { int due; bit en; bit we; logic [14:0] addr; logic [23:0] wdata; } cmd_t;
  typedef struct { int due; logic [23:0] data; } resp_t;
  typedef struct { int due; bit ready; } rdy_t;
  typedef struct { bit we; logic [14:0] addr; logic [23:0] wdata; } hop_t;

  cmd_t  cmd_q[$];
  resp_t disp_q[$];
  resp_t hrd_q[$];
  rdy_t  rdy_q[$];
  hop_t  hreq_q[$];
  logic [23:0] ref_mem [int];
  logic [23:0] last_disp = '0;
  logic [23:0] last_hrd = '0;

  // Power-up contents: line 5 holds g*0x010101, everything else a pattern.
  function automatic logic [23:0] init_val(input logic [14:0] a);
    if (a[14:6] == 9'd5) return 24'(a[5:0]) * 24'h010101;
    return {a, 9'h0} ^ 24'h3C5A96;
  endfunction

  function automatic logic [23:0] ref_rd(input logic [14:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  // Synchronous single-port RAM seen by the DUT.
  logic [23:0] mem [32768];
  bit          mem_wr [32768];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]    <= ram_wdata;
        mem_wr[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
      end
    end
  end

  function automatic bit model_fetch(input int x, input int y, output logic [14:0] a);
    bit last;
    int line, grp;
    last = (x == H_TOTAL - 8);
    line = last ? (y + 1) % V_TOTAL : y;
    grp  = last ? 0 : x / 8 + 1;
    a    = 15'(line * 64 + grp);
    return (x % 8 == 0) && (x < H_ACTIVE - 8 || last) && (line < V_ACTIVE);
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic hop_t rand_op();
    hop_t h;
    h.we    = 1'($urandom_range(0, 1));
    h.addr  = $urandom_range(0, 1) ? 15'($urandom_range(0, 32767))
                                   : 15'(15'h0140 + 15'($urandom_range(0, 7)));
    h.wdata = 24'($urandom);
    return h;
  endfunction

  // One clock of stimulus; records what the DUT must do as a consequence.
  task automatic step(input int x, input int y);
    cmd_t        c;
    hop_t        h;
    bit          f;
    logic [14:0] fa;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix_x = 10'(x);
    pix_y = 9'(y);
    host_valid = (hreq_q.size() != 0);
    if (host_valid) begin
      host_we    = hreq_q[0].we;
      host_addr  = hreq_q[0].addr;
      host_wdata = hreq_q[0].wdata;
    end
    f = model_fetch(x, y, fa);
    rdy_q.push_back('{cyc, !f});
    c = '{cyc + 1, 1'b0, 1'b0, 15'd0, 24'd0};
    if (f) begin
      c.en = 1'b1;
      c.addr = fa;
      disp_q.push_back('{cyc + 3, ref_rd(fa)});
    end else if (host_valid) begin
      h = hreq_q.pop_front();
      c.en = 1'b1;
      c.we = h.we;
      c.addr = h.addr;
      c.wdata = h.wdata;
      if (h.we) ref_mem[int'(h.addr)] = h.wdata;
      else      hrd_q.push_back('{cyc + 3, ref_rd(h.addr)});
    end
    cmd_q.push_back(c);
  endtask

  task automatic run(input int x0, input int y0, input int n, input bit rnd);
    int x, y;
    x = x0;
    y = y0;
    for (int i = 0; i < n; i++) begin
      if (rnd && hreq_q.size() == 0 && $urandom_range(0, 9) < 6) hreq_q.push_back(rand_op());
      step(x, y);
      x++;
      if (x == H_TOTAL) begin
        x = 0;
        y = (y + 1) % V_TOTAL;
      end
    end
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    rst_n = 1'b0;
    host_valid = 1'b0;
    cmd_q.delete(); disp_q.delete(); hrd_q.delete(); rdy_q.delete(); hreq_q.delete();
    repeat (hold) @(posedge clk);
  endtask

  always @(negedge clk) begin : monitor
    cmd_t  c;
    resp_t d;
    rdy_t  r;
    if (!rst_n) begin
      check("reset_outputs", {host_ready, ram_en, ram_we, ram_addr, ram_wdata, disp_word,
                              disp_load, host_rdata, host_rvalid}, '0);
      last_disp = '0;
      last_hrd  = '0;
    end else begin
      if (disp_load) disp_cnt++;
      if (rdy_q.size() != 0 && rdy_q[0].due == cyc) begin
        r = rdy_q.pop_front();
        check("host_ready", host_ready, r.ready);
      end
      if (cmd_q.size() != 0 && cmd_q[0].due == cyc) begin
        c = cmd_q.pop_front();
        check("ram_en", ram_en, c.en);
        if (c.en) check("ram_cmd", {ram_we, ram_addr}, {c.we, c.addr});
        if (c.en && c.we) check("ram_wdata", ram_wdata, c.wdata);
      end
      if (disp_q.size() != 0 && disp_q[0].due == cyc) begin
        d = disp_q.pop_front();
        check("disp_load", disp_load, 1'b1);
        check("disp_word", disp_word, d.data);
        last_disp = d.data;
      end else begin
        check("disp_load_idle", disp_load, 1'b0);
        check("disp_hold", disp_word, last_disp);
      end
      if (hrd_q.size() != 0 && hrd_q[0].due == cyc) begin
        d = hrd_q.pop_front();
        check("host_rvalid", host_rvalid, 1'b1);
        check("host_rdata", host_rdata, d.data);
        last_hrd = d.data;
      end else begin
        check("host_rvalid_idle", host_rvalid, 1'b0);
        check("host_rdata_hold", host_rdata, last_hrd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);

    // Line 4 tail prefetches line 5 group 0; then the full line 5 sweep.
    run(752, 4, 16, 1'b0);
    disp_cnt = 0;
    run(0, 5, 768, 1'b0);
    @(negedge clk); #1;
    check("line5_loads", disp_cnt, 64);

    // Frame wrap and the last visible line.
    run(752, 511, 32, 1'b0);
    run(752, 479, 32, 1'b0);

    // Host write held across the F slot at x=16.
    run(10, 5, 6, 1'b0);
    hreq_q.push_back('{1'b1, 15'h1234, 24'hABCDEF});
    run(16, 5, 6, 1'b0);

    // Write-then-read during vertical blanking.
    hreq_q.push_back('{1'b1, 15'h7FFF, 24'h5A5A5A});
    hreq_q.push_back('{1'b0, 15'h7FFF, 24'h000000});
    run(100, 490, 10, 1'b0);
    check("readback_value", host_rdata, 24'h5A5A5A);

    // Four back-to-back reads straddling the F slot at x=8.
    for (int i = 1; i <= 4; i++) hreq_q.push_back('{1'b0, 15'(15'h0140 + i), 24'h0});
    run(5, 5, 12, 1'b0);

    // Reset with a host read in its command stage.
    run(600, 100, 4, 1'b0);
    hreq_q.push_back('{1'b0, 15'h0143, 24'h0});
    run(20, 5, 1, 1'b0);
    do_reset(3);
    run(21, 5, 30, 1'b0);

    // Random positions with random host traffic.
    for (int k = 0; k < 20; k++)
      run(int'($urandom_range(0, H_TOTAL - 1)), int'($urandom_range(0, V_TOTAL - 1)), 80, 1'b1);

    run(0, 490, 12, 1'b0);
    @(negedge clk); #1;
    check("drain", disp_q.size() + hrd_q.size() + hreq_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Time-slot arbiter sharing one single-port synchronous framebuffer RAM between VGA scan-out and a host write/read port. Sits between the pixel timing counters (768-clock line, 9-bit line counter) and the RAM. It reserves one RAM cycle per 8-pixel group for display prefetch and grants every other cycle to the host through a valid/ready handshake. The block delivers 24-bit words (8 pixels × 3-bit RGB) to the pixel shifter.

## Interface
- `H_TOTAL`, 768: clocks per line; multiple of 8.
- `H_ACTIVE`, 512: visible pixels per line; multiple of 8, 16..512.
- `V_TOTAL`, 512: lines per frame.
- `V_ACTIVE`, 480: visible lines; ≤ 512.

- `clk` input 1: pixel clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pix_x` input 10: current horizontal count, 0..H_TOTAL-1.
- `pix_y` input 9: current line count, 0..V_TOTAL-1.
- `host_valid` input 1: host request pending.
- `host_ready` output 1: grant; a transfer occurs when valid && ready.
- `host_we` input 1: 1 = write, 0 = read.
- `host_addr` input 15: word address, {line[8:0], group[5:0]}.
- `host_wdata` input 24: write data.
- `host_rdata` output 24: read data.
- `host_rvalid` output 1: one-cycle pulse; host_rdata valid.
- `ram_en` output 1: RAM access strobe (registered).
- `ram_we` output 1: RAM write enable (registered).
- `ram_addr` output 15: RAM address (registered).
- `ram_wdata` output 24: RAM write data (registered).
- `ram_rdata` input 24: RAM read data, valid the cycle after ram_en && !ram_we.
- `disp_word` output 24: next 8-pixel word for the shifter.
- `disp_load` output 1: one-cycle pulse; disp_word updated.

## Operation
- **Fetch cycle (F):** pix_x[2:0]==0 and either pix_x < H_ACTIVE-8 or pix_x == H_TOTAL-8, and the target line < V_ACTIVE.
  - Target group g = 0 when pix_x == H_TOTAL-8; otherwise g = pix_x/8 + 1.
  - Target line = pix_y+1 when pix_x == H_TOTAL-8 (wrap: V_TOTAL-1 → 0); otherwise pix_y.
  - Display address = {line, g[5:0]}.
- **host_ready:** combinational, = !F && rst_n. It must not depend on host_valid.
- **Arbitration cycle T:**
  - If F: register a display read.
  - Else if host_valid: register a host op.
  - Else: ram_en = 0 at T+1.
- **Command stage (T+1):** ram_en, ram_we, ram_addr, ram_wdata carry the op. Display reads always have ram_we = 0.
- **Return stage (T+2):** ram_rdata is valid. A 2-deep tag pipeline (none/display/host-read) routes it.
- **Output stage (T+3):**
  - Display tag: disp_word <= ram_rdata, disp_load = 1.
  - Host-read tag: host_rdata <= ram_rdata, host_rvalid = 1.
  - Host writes produce no response.
- **Exclusivity:** at most one RAM op per cycle. The display op is never dropped or delayed. The host may stall indefinitely only if F were permanent, which cannot occur.
- **Held output data:** disp_word and host_rdata hold their value between pulses.
- **Blanking:** no display fetch occurs on lines ≥ V_ACTIVE, or for x in [H_ACTIVE-8, H_TOTAL-9]. The host owns all of those cycles.

## Timing
- **Reset (async assert, sync-safe release):** ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, disp_word = 0, disp_load = 0, host_rdata = 0, host_rvalid = 0, tag pipeline cleared. host_ready = 0 while rst_n = 0.
- **Reset mid-operation:** in-flight reads are discarded. No disp_load or host_rvalid pulse may follow from a pre-reset request.
- **Latency:** request/grant at T → RAM command at T+1 → data at T+3 (disp_load or host_rvalid).
- **Display margin:** a fetch at pix_x = 8g-8 loads at pix_x = 8g-5, 5 clocks before group g starts shifting.
- **Throughput:**
  - Host: 1 op/cycle outside F cycles.
  - Back-to-back host reads: consecutive rvalid pulses, in order.
- **Simultaneous events:** host_valid during F → host_ready = 0. The host request is held by the host and accepted at the next non-F cycle (F+1 is never F).
- **Write-then-read:** a host write at T followed by a read of the same address at T+1 returns the new data (RAM write-first is not required, since the ops use separate cycles).

## Test plan
- **Reset:** assert rst_n = 0 mid-frame with a host read in flight → all outputs 0, no rvalid after release, host_ready = 0 during reset.
- **Display fetch sequence:** run pix_y = 5 with H_ACTIVE = 512, pix_x sweep; preload RAM[{5,g}] = g*0x010101 → 63 disp_load pulses at pix_x = 3, 11, …, 499 with words for g = 1..63. At pix_x = 763, disp_word = RAM[{6,0}].
- **Frame wrap:** pix_y = 511, pix_x = 760 → ram_addr = {0,0} at pix_x = 761. On pix_y = 479, pix_x = 760 → no fetch (target line 480).
- **Host contention:** host_valid held with write addr 0x1234, data 0xABCDEF at pix_x = 16 (F) → host_ready = 0 at 16, transfer at 17, ram_we = 1 at 18. No disp_load lost.
- **Host readback:** write 0x5A5A5A to 0x7FFF, then read it during blanking (pix_y = 490) → host_rvalid 3 cycles after read handshake, host_rdata = 0x5A5A5A.
- **Back-to-back reads:** 4 reads straddling an F cycle → 4 in-order rvalid pulses with a one-cycle gap at the F slot. ram_en never asserts twice in one cycle.
